// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port and a
// per-register busy scoreboard that raises STALL on RAW hazards.
// Optional write-through forwarding: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     RW,
  input  logic [ADDR_W-1:0]        DA,
  input  logic [DATA_W-1:0]        BUS_D,
  input  logic [ADDR_W-1:0]        AA,
  input  logic [ADDR_W-1:0]        BA,
  input  logic                     USE_A,
  input  logic                     USE_B,
  input  logic                     ISSUE,
  input  logic [ADDR_W-1:0]        ISSUE_DA,
  output logic [DATA_W-1:0]        A_DATA,
  output logic [DATA_W-1:0]        B_DATA,
  output logic                     STALL,
  output logic [(2**ADDR_W)-1:0]   BUSY_MAP
);

  localparam int NREG    = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;

  logic              wr_en;
  logic              fwd_a, fwd_b;
  logic              zero_a, zero_b;
  logic              pend_a, pend_b;
  logic              stall;
  logic [DATA_W-1:0] a_val, b_val;

  assign zero_a = ZERO_EN && (AA == '0);
  assign zero_b = ZERO_EN && (BA == '0);
  assign wr_en  = RW && !(ZERO_EN && (DA == '0));

`ifdef REGFILE_BYPASS_EN
  // A register being written this cycle is already available on the read port.
  assign fwd_a = RW && (DA == AA);
  assign fwd_b = RW && (DA == BA);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign a_val = zero_a ? '0 : (fwd_a ? BUS_D : regs_q[AA]);
  assign b_val = zero_b ? '0 : (fwd_b ? BUS_D : regs_q[BA]);

  assign pend_a = busy_q[AA] && !fwd_a && !zero_a;
  assign pend_b = busy_q[BA] && !fwd_b && !zero_b;

  // Reset forces quiet outputs even while write-back is still driving BUS_D.
  assign stall  = RESET && ((USE_A && pend_a) || (USE_B && pend_b));
  assign STALL  = stall;
  assign A_DATA = RESET ? a_val : '0;
  assign B_DATA = RESET ? b_val : '0;
  assign BUSY_MAP = busy_q;

  // NOTE: always_comb uses blocking assignments and starts from the current
  // state so every path assigns every bit; no latch can be inferred.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[DA] = BUS_D;
    end

    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      // Set beats clear: the newly issued instruction owns the register.
      if (ISSUE && !stall && (ISSUE_DA == ADDR_W'(i)) && !(ZERO_EN && i == 0)) begin
        busy_d[i] = 1'b1;
      end else if (RW && (DA == ADDR_W'(i))) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  // NOTE: the register array is reset because reads must return 0 after reset;
  // sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared against an array-based model.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        RW;
  logic [4:0]  DA;
  logic [31:0] BUS_D;
  logic [4:0]  AA, BA;
  logic        USE_A, USE_B;
  logic        ISSUE;
  logic [4:0]  ISSUE_DA;
  logic [31:0] A_DATA, B_DATA;
  logic        STALL;
  logic [31:0] BUSY_MAP;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  always #5 CLOCK = ~CLOCK;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .RW(RW), .DA(DA), .BUS_D(BUS_D),
    .AA(AA), .BA(BA), .USE_A(USE_A), .USE_B(USE_B),
    .ISSUE(ISSUE), .ISSUE_DA(ISSUE_DA),
    .A_DATA(A_DATA), .B_DATA(B_DATA), .STALL(STALL), .BUSY_MAP(BUSY_MAP)
  );

  // Reference model: stored values and pending flags per register.
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fwd(input logic [4:0] a);
    return BYPASS && RW && (DA == a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!RESET || a == 5'd0) return 32'd0;
    if (m_fwd(a)) return BUS_D;
    return m_reg[a];
  endfunction

  function automatic logic exp_stall();
    if (!RESET) return 1'b0;
    return (USE_A && m_busy[AA] && !m_fwd(AA)) || (USE_B && m_busy[BA] && !m_fwd(BA));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_busy = 32'd0;
  endtask

  // Apply one clock edge worth of architectural effect: write-back retires first,
  // then an accepted issue marks its destination (so issue wins on a tie).
  task automatic model_update();
    logic st;
    st = exp_stall();
    if (RW) begin
      if (DA != 5'd0) m_reg[DA] = BUS_D;
      m_busy[DA] = 1'b0;
    end
    if (ISSUE && !st && ISSUE_DA != 5'd0) m_busy[ISSUE_DA] = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLOCK);
    if (RESET) model_update();
    #1;
  endtask

  task automatic idle();
    RW = 1'b0; ISSUE = 1'b0; USE_A = 1'b0; USE_B = 1'b0;
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // Continuous comparison of every output against the model, mid-cycle.
  always @(negedge CLOCK) begin
    if (checking) begin
      check("cmp_a_data", A_DATA, exp_read(AA));
      check("cmp_b_data", B_DATA, exp_read(BA));
      check("cmp_stall", {31'd0, STALL}, {31'd0, exp_stall()});
      check("cmp_busy_map", BUSY_MAP, m_busy);
    end
  end

  initial begin
    RESET = 1'b0; idle();
    DA = 5'd0; BUS_D = 32'd0; ISSUE_DA = 5'd0;
    AA = 5'd5; BA = 5'd31;
    model_reset();
    // Write-back activity during reset must have no effect.
    RW = 1'b1; DA = 5'd5; BUS_D = 32'hCAFE_F00D; ISSUE = 1'b1; ISSUE_DA = 5'd5;
    #1;
    checking = 1'b1;
    tick();
    tick();
    check("rst_a_data", A_DATA, 32'd0);
    check("rst_b_data", B_DATA, 32'd0);
    check("rst_busy_map", BUSY_MAP, 32'd0);
    check("rst_stall", {31'd0, STALL}, 32'd0);
    RESET = 1'b1; idle();
    #1;
    check("post_rst_a5", A_DATA, 32'd0);

    // Plain write then read next cycle; writes to R0 are dropped.
    RW = 1'b1; DA = 5'd7; BUS_D = 32'hDEAD_BEEF;
    tick();
    RW = 1'b0; AA = 5'd7;
    #1 check("read_r7", A_DATA, 32'hDEAD_BEEF);
    RW = 1'b1; DA = 5'd0; BUS_D = 32'h0000_1234;
    tick();
    RW = 1'b0; AA = 5'd0;
    #1 check("read_r0", A_DATA, 32'd0);

    // RAW hazard on R3.
    ISSUE = 1'b1; ISSUE_DA = 5'd3;
    tick();
    ISSUE = 1'b0; AA = 5'd3; USE_A = 1'b1;
    #1 check("hazard_stall", {31'd0, STALL}, 32'd1);
    check("hazard_busy3", {31'd0, BUSY_MAP[3]}, 32'd1);
    RW = 1'b1; DA = 5'd3; BUS_D = 32'h0000_0055;
    #1;
    if (BYPASS) begin
      check("wb_cycle_stall", {31'd0, STALL}, 32'd0);
      check("wb_cycle_a", A_DATA, 32'h0000_0055);
    end else begin
      check("wb_cycle_stall", {31'd0, STALL}, 32'd1);
    end
    tick();
    RW = 1'b0;
    #1 check("after_wb_stall", {31'd0, STALL}, 32'd0);
    check("after_wb_a", A_DATA, 32'h0000_0055);
    check("after_wb_busy3", {31'd0, BUSY_MAP[3]}, 32'd0);

    // Issue and write-back hit R9 together: issue wins.
    USE_A = 1'b0;
    ISSUE = 1'b1; ISSUE_DA = 5'd9; RW = 1'b1; DA = 5'd9; BUS_D = 32'h9999_0000;
    tick();
    idle();
    #1 check("set_wins_busy9", {31'd0, BUSY_MAP[9]}, 32'd1);

    // Issue under stall is ignored.
    BA = 5'd9; USE_B = 1'b1; ISSUE = 1'b1; ISSUE_DA = 5'd12;
    #1 check("gated_stall", {31'd0, STALL}, 32'd1);
    tick();
    idle();
    #1 check("gated_busy12", {31'd0, BUSY_MAP[12]}, 32'd0);

    // Reset in the middle of a write with R4/R6 pending.
    RW = 1'b1; DA = 5'd9; BUS_D = 32'h1;
    tick();
    idle(); ISSUE = 1'b1; ISSUE_DA = 5'd4;
    tick();
    ISSUE_DA = 5'd6;
    tick();
    idle();
    #1 check("pending_4_6", BUSY_MAP, 32'h0000_0050);
    RW = 1'b1; DA = 5'd4; BUS_D = 32'h0000_00AA; AA = 5'd4;
    #2 RESET = 1'b0;
    model_reset();
    #1 check("midrst_busy", BUSY_MAP, 32'd0);
    tick();
    RESET = 1'b1; RW = 1'b0;
    #1 check("midrst_r4", A_DATA, 32'd0);
    check("midrst_busy_after", BUSY_MAP, 32'd0);

    // Randomized traffic, concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b0;
        model_reset();
        tick();
        RESET = 1'b1;
      end
      RW       = ($urandom_range(0, 9) < 4);
      DA       = rnd_addr();
      BUS_D    = $urandom;
      AA       = rnd_addr();
      BA       = rnd_addr();
      USE_A    = $urandom_range(0, 1) == 1;
      USE_B    = $urandom_range(0, 1) == 1;
      ISSUE    = ($urandom_range(0, 9) < 4);
      ISSUE_DA = rnd_addr();
      tick();
    end

    idle();
    tick();
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register file that receives the write-back stage's outputs (BUS_D, RW_out, DA_out) and serves operands to decode/operand-fetch.
- Two asynchronous read ports, one synchronous write port.
- Per-register busy scoreboard: decode marks a destination pending on issue, and write-back clears it.
- Raises STALL when a required source operand is still pending.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 5, register address width; 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked busy.

Ports:
- CLOCK  in  1  system clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- RW  in  1  write enable from write-back.
- DA  in  ADDR_W  write address from write-back.
- BUS_D  in  DATA_W  write data from write-back.
- AA  in  ADDR_W  read address, port A.
- BA  in  ADDR_W  read address, port B.
- USE_A  in  1  current decode needs port A.
- USE_B  in  1  current decode needs port B.
- ISSUE  in  1  decode issuing an instruction that writes ISSUE_DA.
- ISSUE_DA  in  ADDR_W  destination of the issuing instruction.
- A_DATA  out  DATA_W  read data, port A (combinational).
- B_DATA  out  DATA_W  read data, port B (combinational).
- STALL  out  1  operand hazard; decode must hold.
- BUSY_MAP  out  2**ADDR_W  registered busy bits, for debug and verification.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All registers become 0 and BUSY_MAP becomes 0.
  - STALL=0 while in reset; A_DATA and B_DATA read 0.
  - Reset asserted mid-write discards the write.
  - Reset has priority over every other input.
- Write:
  - At posedge with RW=1 and DA!=0 (or ZERO_REG=0), reg[DA] takes BUS_D.
  - Visible on A_DATA/B_DATA from the following cycle; same-cycle visibility is covered under Optional Feature.
- Read:
  - A_DATA = reg[AA] and B_DATA = reg[BA], combinational.
  - Address 0 returns 0 when ZERO_REG=1.
- Scoreboard, per register i, at posedge:
  - set_i = ISSUE & ~STALL & (ISSUE_DA==i) & ~(ZERO_REG & i==0).
  - clr_i = RW & (DA==i).
  - If set_i, busy_i becomes 1. Set wins over a simultaneous clear, because the newer instruction owns the register.
  - Else if clr_i, busy_i becomes 0.
  - Otherwise busy_i holds.
- ISSUE while STALL=1 is ignored: no busy bit is set, and decode re-presents the instruction.
- Write-back to a register that is not busy: the data is written and the busy bit stays 0; no error.
- Multiple outstanding writers to one register are not tracked. The first WB write clears busy; preventing this case is decode's responsibility.
- STALL (combinational):
  - STALL = (USE_A & pend(AA)) | (USE_B & pend(BA)).
  - pend(x) = busy_x & ~fwd(x).
  - fwd(x) is defined under Optional Feature; with the feature out, fwd=0.
  - An address of 0 with ZERO_REG=1 is never pending.
- Latency: issue-to-busy 1 cycle; WB-write-to-busy-clear 1 cycle; no other internal pipelining.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding):
  - When RW=1 and DA==AA (nonzero or ZERO_REG=0), A_DATA = BUS_D in the same cycle; port B likewise with BA.
  - fwd(x) = RW & (DA==x), so a register being written this cycle does not stall.
  - Saves one stall cycle per RAW hazard.
- Not defined:
  - Reads return stored contents only.
  - STALL persists until the cycle after the WB write, when busy is clear.

Test Plan:
- Reset then read: RESET low 2 cycles → A_DATA=B_DATA=0 for AA=5, BA=31; BUSY_MAP=0; STALL=0.
- Write R7=0xDEADBEEF, then AA=7 next cycle → A_DATA=0xDEADBEEF. Write R0=0x1234 → AA=0 reads 0.
- Hazard: ISSUE R3; next cycle AA=3, USE_A=1 → STALL=1. WB RW=1, DA=3, BUS_D=0x55:
  - With bypass: STALL=0 and A_DATA=0x55 that cycle.
  - Without bypass: STALL=0 one cycle later.
- Simultaneous: ISSUE R9 and WB RW=1, DA=9 in the same cycle → BUSY_MAP[9]=1 afterwards.
- Gated issue: STALL=1 (USE_B=1, BA busy) while ISSUE R12 → BUSY_MAP[12] stays 0.
- Reset mid-operation: busy R4/R6 pending, drop RESET during a write to R4=0xAA → BUSY_MAP=0 and R4 reads 0 after release.
